// File: rtl/seg_pkg.sv
// Shared constants, state type and helpers for the 8-digit seven-segment scanner.
// Leading-zero blanking helper is used only when SEG_SCAN_LZ_BLANK_EN is defined.
package seg_pkg;

    localparam int NUM_DIGITS   = 8;
    localparam int DEF_CLK_DIV  = 100000;
    localparam int DEF_DEAD_CYC = 4;

    typedef enum logic {
        DEAD = 1'b0,
        SHOW = 1'b1
    } state_t;

    // True when digit idx (>0) and every digit above it are zero.
    function automatic logic lz_blank(
        input logic [31:0] val,
        input logic [2:0]  idx
    );
        logic b;
        b = (idx != 3'd0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && val[4*k +: 4] != 4'h0) begin
                b = 1'b0;
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Slot prescaler: counts 0..CLK_DIV-1 and wraps; tc flags the last count.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [$clog2(CLK_DIV)-1:0] count,
    output logic                       tc
);

    localparam int            W    = $clog2(CLK_DIV);
    localparam logic [W-1:0]  LAST = W'(CLK_DIV - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tc) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 8-digit display scanner with dead time and frame-atomic updates.
// Optional leading-zero blanking: define SEG_SCAN_LZ_BLANK_EN.
module seg_scan
    import seg_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int DEAD_CYC = DEF_DEAD_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] din,
    input  logic        load,
    output logic [7:0]  an,
    output logic [3:0]  nibble,
    output logic        frame
);

    localparam int           W         = $clog2(CLK_DIV);
    localparam logic [W-1:0] DEAD_LAST = W'(DEAD_CYC - 1);

    logic [W-1:0] count;
    logic         tc;
    logic [2:0]   idx;
    state_t       state;
    state_t       state_nxt;
    logic [31:0]  disp;
    logic [31:0]  pend;
    logic         armed;
    logic         wrap;
    logic         blank;
    logic [7:0]   an_nxt;

    seg_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count),
        .tc    (tc)
    );

    assign wrap = tc && (idx == 3'd7);

`ifdef SEG_SCAN_LZ_BLANK_EN
    assign blank = lz_blank(disp, idx);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            DEAD: if (count == DEAD_LAST) state_nxt = SHOW;
            SHOW: if (tc) state_nxt = DEAD;
        endcase
    end

    always_comb begin
        an_nxt = 8'hFF;
        if (state == SHOW && !blank) begin
            an_nxt = ~(8'h01 << idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD;
            idx   <= 3'd0;
            armed <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= armed | tc;
            if (tc) idx <= idx + 3'd1;
        end
    end

    // A load on the wrap edge bypasses pending so the new frame uses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= 32'h0;
            disp <= 32'h0;
        end else begin
            if (load) pend <= din;
            if (wrap) disp <= load ? din : pend;
        end
    end

    // Outputs trail the scan state by one registered stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an     <= 8'hFF;
            nibble <= 4'h0;
            frame  <= 1'b0;
        end else begin
            an     <= an_nxt;
            nibble <= disp[{idx, 2'b00} +: 4];
            frame  <= (count == '0) && (idx == 3'd0) && armed;
        end
    end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan with CLK_DIV=4, DEAD_CYC=1.
// Define SEG_SCAN_LZ_BLANK_EN for both RTL and bench to check blanking.
module tb_seg_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] din = 32'h0;
    logic        load = 1'b0;
    logic [7:0]  an;
    logic [3:0]  nibble;
    logic        frame;

    int tests = 0;
    int fails = 0;

    int          n = 0;
    logic [31:0] last = 32'h0;
    logic [31:0] fval [int];

    int          t, cnt, dig, f;
    logic [31:0] v;
    logic [7:0]  ea;
    logic [3:0]  en;
    logic        ef;

    seg_scan #(
        .CLK_DIV  (4),
        .DEAD_CYC (1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .din    (din),
        .load   (load),
        .an     (an),
        .nibble (nibble),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: edge n after release shows scan position n-1; frames are 32 edges.
    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0;
            last = 32'h0;
            fval.delete();
            fval[0] = 32'h0;
            #1;
            chk("rst_an", {24'h0, an}, 32'hFF);
            chk("rst_nib", {28'h0, nibble}, 32'h0);
            chk("rst_frame", {31'h0, frame}, 32'h0);
        end else begin
            n = n + 1;
            if (load) last = din;
            if (n % 32 == 0) fval[n / 32] = last;
            #1;
            t   = n - 1;
            cnt = t % 4;
            dig = (t / 4) % 8;
            f   = t / 32;
            v   = fval.exists(f) ? fval[f] : 32'h0;
            ea  = (cnt == 0) ? 8'hFF : ~(8'h01 << dig);
`ifdef SEG_SCAN_LZ_BLANK_EN
            if (dig > 0 && (v >> (4 * dig)) == 32'h0) ea = 8'hFF;
`endif
            en  = 4'(v >> (4 * dig));
            ef  = (cnt == 0) && (dig == 0) && (f > 0);
            chk("an", {24'h0, an}, {24'h0, ea});
            chk("nibble", {28'h0, nibble}, {28'h0, en});
            chk("frame", {31'h0, frame}, {31'h0, ef});
        end
    end

    task automatic wait_n(input int k);
        int g = 0;
        while (n < k && g < 20000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_n", n, k);
    endtask

    task automatic wait_slot(input int d, input int c);
        int g = 0;
        while (!(n > 0 && ((n - 1) % 32) / 4 == d && (n - 1) % 4 == c)
               && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("wait_slot", {31'h0, g < 200}, 32'h1);
    endtask

    task automatic pulse_load(input logic [31:0] val);
        load = 1'b1;
        din  = val;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("lit_rst_an", {24'h0, an}, 32'hFF);
        chk("lit_rst_nib", {28'h0, nibble}, 32'h0);
        rst_n = 1'b1;

        wait_n(1);
        chk("lit_e1_an", {24'h0, an}, 32'hFF);
        chk("lit_e1_frame", {31'h0, frame}, 32'h0);
        pulse_load(32'h89ABCDEF);

        wait_n(33);
        chk("lit_d0_dead", {24'h0, an}, 32'hFF);
        chk("lit_d0_nib", {28'h0, nibble}, 32'hF);
        chk("lit_frame1", {31'h0, frame}, 32'h1);
        wait_n(34);
        chk("lit_d0_show", {24'h0, an}, 32'hFE);
        chk("lit_frame0", {31'h0, frame}, 32'h0);
        wait_n(62);
        chk("lit_d7_an", {24'h0, an}, 32'h7F);
        chk("lit_d7_nib", {28'h0, nibble}, 32'h8);

        wait_n(77);
        pulse_load(32'h11111111);
        wait_n(85);
        pulse_load(32'h22222222);
        wait_n(94);
        chk("lit_old_d7", {28'h0, nibble}, 32'h8);
        wait_n(98);
        chk("lit_new_d0", {28'h0, nibble}, 32'h2);

        wait_n(127);
        pulse_load(32'h0000000A);
        wait_n(130);
        chk("lit_wrap_an", {24'h0, an}, 32'hFE);
        chk("lit_wrap_nib", {28'h0, nibble}, 32'hA);
        wait_n(134);
        chk("lit_wrap_d1", {28'h0, nibble}, 32'h0);

        repeat (640) begin
            @(negedge clk);
            load = ($urandom_range(0, 7) == 0);
            din  = $urandom;
        end
        @(negedge clk);
        load = 1'b0;

        wait_slot(2, 1);
        pulse_load(32'hDEADBEEF);
        wait_slot(4, 1);
        chk("lit_pre_rst_an", {24'h0, an}, 32'hEF);
        #3 rst_n = 1'b0;
        #1;
        chk("lit_async_an", {24'h0, an}, 32'hFF);
        chk("lit_async_nib", {28'h0, nibble}, 32'h0);
        chk("lit_async_frame", {31'h0, frame}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_n(1);
        chk("lit_restart_an", {24'h0, an}, 32'hFF);
        wait_n(2);
        chk("lit_restart_d0", {24'h0, an}, 32'hFE);
        wait_n(34);
        chk("lit_discard", {28'h0, nibble}, 32'h0);

`ifdef SEG_SCAN_LZ_BLANK_EN
        pulse_load(32'h00000305);
        wait_n(66);
        chk("lz_d0_an", {24'h0, an}, 32'hFE);
        chk("lz_d0_nib", {28'h0, nibble}, 32'h5);
        wait_n(70);
        chk("lz_d1_an", {24'h0, an}, 32'hFD);
        wait_n(74);
        chk("lz_d2_an", {24'h0, an}, 32'hFB);
        chk("lz_d2_nib", {28'h0, nibble}, 32'h3);
        wait_n(78);
        chk("lz_d3_an", {24'h0, an}, 32'hFF);
        wait_n(94);
        chk("lz_d7_an", {24'h0, an}, 32'hFF);
`endif

        repeat (40) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
